// File: rtl/interval_sched_if.sv
// Client-side bus of interval_sched: request/length in, grant/status out.
// With SCHED_ABORT_EN defined the bus also carries abort/aborted.
interface interval_sched_if #(
    parameter int unsigned WIDTH = 5
);
    logic [1:0]       req;
    logic [WIDTH-1:0] len0;
    logic [WIDTH-1:0] len1;
    logic [1:0]       grant;
    logic             busy;
    logic [WIDTH-1:0] count;
    logic [1:0]       done;
`ifdef SCHED_ABORT_EN
    logic             abort;
    logic             aborted;

    modport master (
        output req, len0, len1, abort,
        input  grant, busy, count, done, aborted
    );
    modport slave (
        input  req, len0, len1, abort,
        output grant, busy, count, done, aborted
    );
`else
    modport master (
        output req, len0, len1,
        input  grant, busy, count, done
    );
    modport slave (
        input  req, len0, len1,
        output grant, busy, count, done
    );
`endif
endinterface

// File: rtl/interval_sched.sv
// interval_sched: round-robin scheduler sharing one loadable up-counter between two clients.
// Optional SCHED_ABORT_EN adds abort (input) and aborted (one-cycle pulse) on the bus.
module interval_sched #(
    parameter int unsigned WIDTH = 5
) (
    input  logic           clk,
    input  logic           rst,
    interval_sched_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [1:0]       done_q, done_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic             rr_q, rr_d;
    logic             aborted_q, aborted_d;

    logic             pick;
    logic [WIDTH-1:0] pick_len;

    always_comb begin
        // rr_q holds the last served index; on a tie the other client wins
        pick     = (bus.req == 2'b11) ? ~rr_q : bus.req[1];
        pick_len = pick ? bus.len1 : bus.len0;

        state_d   = state_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        count_d   = count_q;
        done_d    = '0;
        len_d     = len_q;
        rr_d      = rr_q;
        aborted_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req != 2'b00) begin
                    len_d   = pick_len;
                    grant_d = pick ? 2'b10 : 2'b01;
                    rr_d    = pick;
                    busy_d  = 1'b1;
                    count_d = '0;
                    if (pick_len == '0) begin
                        state_d = S_DONE;
                        done_d  = pick ? 2'b10 : 2'b01;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
`ifdef SCHED_ABORT_EN
                if (bus.abort) begin
                    state_d   = S_IDLE;
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    count_d   = '0;
                    aborted_d = 1'b1;
                end else
`endif
                // terminating at len_q-1 keeps the counter from ever wrapping
                if (count_q == len_q - WIDTH'(1)) begin
                    state_d = S_DONE;
                    count_d = '0;
                    done_d  = grant_q;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            count_q   <= '0;
            done_q    <= '0;
            len_q     <= '0;
            rr_q      <= 1'b1;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
            done_q    <= done_d;
            len_q     <= len_d;
            rr_q      <= rr_d;
            aborted_q <= aborted_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;
    assign bus.count = count_q;
    assign bus.done  = done_q;
`ifdef SCHED_ABORT_EN
    assign bus.aborted = aborted_q;
`else
    logic unused_aborted;
    assign unused_aborted = aborted_q;
`endif
endmodule

// File: tb/tb_interval_sched.sv
// Bench for interval_sched: per-cycle expected outputs are queued when a job is
// requested and popped/compared one per clock.
module tb_interval_sched;
    localparam int unsigned W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    interval_sched_if #(.WIDTH(W)) bus ();
    interval_sched #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [1:0]   grant;
        logic         busy;
        logic [W-1:0] count;
        logic [1:0]   done;
        logic         ab;
    } exp_t;

    typedef struct {
        logic [1:0]   req;
        logic [W-1:0] len0;
        logic [W-1:0] len1;
        logic [1:0]   g;
        int unsigned  len;
        bit           drop;
    } vec_t;

    exp_t        exp_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;
    string       tag   = "init";
    vec_t        vecs[7];

    task automatic push(input logic [1:0] g, input logic b, input int unsigned c,
                        input logic [1:0] d, input logic ab);
        exp_t e;
        e.grant = g; e.busy = b; e.count = W'(c); e.done = d; e.ab = ab;
        exp_q.push_back(e);
    endtask

    task automatic push_idle(input int unsigned n);
        repeat (n) push(2'b00, 1'b0, 0, 2'b00, 1'b0);
    endtask

    // grant cycle .. done cycle, then the mandatory IDLE cycle
    task automatic push_job(input logic [1:0] g, input int unsigned len);
        if (len == 0) begin
            push(g, 1'b1, 0, g, 1'b0);
        end else begin
            for (int unsigned i = 0; i < len; i++) push(g, 1'b1, i, 2'b00, 1'b0);
            push(g, 1'b1, 0, g, 1'b0);
        end
        push_idle(1);
    endtask

    task automatic drain(input bit clr, input bit drop);
        exp_t e;
        exp_t act;
        logic act_ab;
        bit   first;
        first = 1'b1;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            cyc++;
            e = exp_q.pop_front();
`ifdef SCHED_ABORT_EN
            act_ab = bus.aborted;
`else
            act_ab = 1'b0;
`endif
            act = {bus.grant, bus.busy, bus.count, bus.done, act_ab};
            n_cmp++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL %s cyc%0d: got grant=%b busy=%b count=%0d done=%b ab=%b, want grant=%b busy=%b count=%0d done=%b ab=%b",
                         tag, cyc, act.grant, act.busy, act.count, act.done, act.ab,
                         e.grant, e.busy, e.count, e.done, e.ab);
            end
            if (clr && e.done != 2'b00) bus.req = bus.req & ~e.done;
            if (drop && first) bus.req = 2'b00;
            first = 1'b0;
            // lengths after grant must not matter
            if (exp_q.size() > 1) begin
                bus.len0 = W'($urandom);
                bus.len1 = W'($urandom);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = 2'b00;
        push_idle(1);
        drain(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        vecs = '{
            '{2'b01, 5'd3,  5'd7, 2'b01, 3,  1'b0},
            '{2'b10, 5'd9,  5'd4, 2'b10, 4,  1'b1},
            '{2'b01, 5'd0,  5'd5, 2'b01, 0,  1'b0},
            '{2'b10, 5'd2,  5'd1, 2'b10, 1,  1'b0},
            '{2'b01, 5'd1,  5'd0, 2'b01, 1,  1'b1},
            '{2'b10, 5'd6,  5'd0, 2'b10, 0,  1'b0},
            '{2'b01, 5'd12, 5'd3, 2'b01, 12, 1'b0}
        };
        bus.req  = 2'b00;
        bus.len0 = '0;
        bus.len1 = '0;
`ifdef SCHED_ABORT_EN
        bus.abort = 1'b0;
`endif

        tag = "reset";
        push_idle(2);
        drain(1'b0, 1'b0);
        rst = 1'b0;
        tag = "idle";
        push_idle(2);
        drain(1'b0, 1'b0);

        for (int i = 0; i < 7; i++) begin
            tag = $sformatf("vec%0d", i);
            bus.len0 = vecs[i].len0;
            bus.len1 = vecs[i].len1;
            bus.req  = vecs[i].req;
            push_job(vecs[i].g, vecs[i].len);
            drain(1'b1, vecs[i].drop);
        end

        do_reset();
        tag = "contend";
        bus.len0 = 5'd2;
        bus.len1 = 5'd4;
        bus.req  = 2'b11;
        push_job(2'b01, 2);
        drain(1'b1, 1'b0);
        bus.len1 = 5'd4;
        push_job(2'b10, 4);
        drain(1'b1, 1'b0);

        do_reset();
        tag = "fair";
        bus.req  = 2'b11;
        bus.len0 = 5'd0;
        bus.len1 = 5'd1;
        push_job(2'b01, 0);
        drain(1'b0, 1'b0);
        bus.len1 = 5'd1;
        push_job(2'b10, 1);
        drain(1'b1, 1'b0);
        bus.req  = 2'b11;
        bus.len0 = 5'd0;
        push_job(2'b01, 0);
        drain(1'b0, 1'b0);
        bus.len1 = 5'd1;
        push_job(2'b10, 1);
        drain(1'b1, 1'b0);
        bus.req = 2'b00;
        push_idle(1);
        drain(1'b0, 1'b0);

        tag = "maxlen";
        bus.len1 = 5'd31;
        bus.req  = 2'b10;
        push_job(2'b10, 31);
        drain(1'b1, 1'b0);

        tag = "midrst";
        bus.len1 = 5'd31;
        bus.req  = 2'b10;
        for (int unsigned i = 0; i <= 10; i++) push(2'b10, 1'b1, i, 2'b00, 1'b0);
        drain(1'b0, 1'b0);
        rst = 1'b1;
        bus.req = 2'b00;
        push_idle(1);
        drain(1'b0, 1'b0);
        rst = 1'b0;
        push_idle(3);
        drain(1'b0, 1'b0);

`ifdef SCHED_ABORT_EN
        do_reset();
        tag = "abort";
        bus.len0 = 5'd8;
        bus.req  = 2'b01;
        for (int unsigned i = 0; i <= 4; i++) push(2'b01, 1'b1, i, 2'b00, 1'b0);
        drain(1'b0, 1'b0);
        bus.abort = 1'b1;
        bus.req   = 2'b11;
        push(2'b00, 1'b0, 0, 2'b00, 1'b1);
        drain(1'b0, 1'b0);
        bus.abort = 1'b0;
        bus.len1  = 5'd2;
        push_job(2'b10, 2);
        drain(1'b1, 1'b0);
        bus.req = 2'b00;
        push_idle(2);
        drain(1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
